dpram_port_arbiter: RTL and testbench

DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

---
 rtl/dpram_pkg.sv | 20 ++
 rtl/dpram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_pkg.sv
// Shared defaults and types for the dual-requester single-port RAM arbiter.
package dpram_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned ADDR_W_DEF    = 6;
  localparam int unsigned MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  // One entry of the read-return tracking shift.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/dpram_port_arbiter.sv
// Arbitrates two requesters onto one synchronous-read RAM port, with round-robin
// selection, bounded lock bursts and in-order read return.
module dpram_port_arbiter
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              lock_0,
  input  logic              lock_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rd_tag_t          rd_s1_q, rd_s2_q;
  logic [DATA_W-1:0] rdata_0_q, rdata_1_q;

  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_0   = 1'b0;
    gnt_1   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_0 && (!req_1 || !ptr_q)) begin
          gnt_0 = 1'b1;
          ptr_d = 1'b1;
          if (lock_0) begin
            state_d = OWN0;
            cnt_d   = OneCnt;
          end
        end else if (req_1) begin
          gnt_1 = 1'b1;
          ptr_d = 1'b0;
          if (lock_1) begin
            state_d = OWN1;
            cnt_d   = OneCnt;
          end
        end
      end
      OWN0: begin
        if (req_0 && lock_0 && (cnt_q < MaxCnt)) begin
          gnt_0 = 1'b1;
          cnt_d = cnt_q + OneCnt;
        end else begin
          // Burst over: hand the port straight to the other side if it waits.
          state_d = IDLE;
          cnt_d   = '0;
          if (req_1) begin
            gnt_1 = 1'b1;
            ptr_d = 1'b0;
          end
        end
      end
      OWN1: begin
        if (req_1 && lock_1 && (cnt_q < MaxCnt)) begin
          gnt_1 = 1'b1;
          cnt_d = cnt_q + OneCnt;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          if (req_0) begin
            gnt_0 = 1'b1;
            ptr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      gnt_0 = 1'b0;
      gnt_1 = 1'b0;
    end
  end

  assign any_gnt  = gnt_0 | gnt_1;
  assign sel_we   = gnt_1 ? we_1    : we_0;
  assign sel_addr = gnt_1 ? addr_1  : addr_0;
  assign sel_din  = gnt_1 ? wdata_1 : wdata_0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rd_s1_q   <= '0;
      rd_s2_q   <= '0;
      rdata_0_q <= '0;
      rdata_1_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ram_we  <= any_gnt & sel_we;
      if (any_gnt) begin
        ram_addr <= sel_addr;
        ram_din  <= sel_din;
      end
      rd_s1_q.valid <= any_gnt & ~sel_we;
      rd_s1_q.id    <= gnt_1;
      rd_s2_q       <= rd_s1_q;
      if (rvalid_0) rdata_0_q <= ram_dout;
      if (rvalid_1) rdata_1_q <= ram_dout;
    end
  end

  // RAM output is only valid in the return cycle, so it bypasses the hold register.
  assign rvalid_0 = rd_s2_q.valid & ~rd_s2_q.id;
  assign rvalid_1 = rd_s2_q.valid &  rd_s2_q.id;
  assign rdata_0  = rvalid_0 ? ram_dout : rdata_0_q;
  assign rdata_1  = rvalid_1 ? ram_dout : rdata_1_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural synchronous-read RAM.
module tb_dpram_port_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 6;

  logic          clk, rst;
  logic          req_0, req_1, lock_0, lock_1, we_0, we_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [DW-1:0] wdata_0, wdata_1;
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [DW-1:0] rdata_0, rdata_1;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [DW-1:0] mem [0:63];

  int pass_cnt = 0;
  int total_cnt = 0;

  dpram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .req_1(req_1), .lock_0(lock_0), .lock_1(lock_1),
    .we_0(we_0), .we_1(we_1), .addr_0(addr_0), .addr_1(addr_1),
    .wdata_0(wdata_0), .wdata_1(wdata_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_0 = 0; req_1 = 0; lock_0 = 0; lock_1 = 0; we_0 = 0; we_1 = 0;
    addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; req_0 = 1; req_1 = 1;
    tick();
    #3;
    total_cnt++;
    if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0)
      $display("FAIL rst_gnt: got %b%b exp 00", gnt_0, gnt_1);
    else pass_cnt++;
    total_cnt++;
    if (ram_we !== 1'b0 || ram_addr !== 6'd0 || ram_din !== 8'd0)
      $display("FAIL rst_ram: got we=%b a=%h d=%h exp 0/0/0", ram_we, ram_addr, ram_din);
    else pass_cnt++;
    total_cnt++;
    if (rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0 || rdata_0 !== 8'd0 || rdata_1 !== 8'd0)
      $display("FAIL rst_rd: got v=%b%b d0=%h d1=%h exp 0", rvalid_0, rvalid_1, rdata_0, rdata_1);
    else pass_cnt++;
    rst = 0; idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    do_reset();
    req_0 = 1; we_0 = 1; addr_0 = 6'd7; wdata_0 = 8'hAA;
    #3;
    total_cnt++;
    if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) $display("FAIL wr_gnt: got %b%b exp 10", gnt_0, gnt_1);
    else pass_cnt++;
    tick();
    req_0 = 0; we_0 = 0; req_1 = 1; we_1 = 0; addr_1 = 6'd7;
    #3;
    total_cnt++;
    if (ram_we !== 1'b1 || ram_addr !== 6'd7 || ram_din !== 8'hAA)
      $display("FAIL wr_ram: got we=%b a=%h d=%h exp 1/07/aa", ram_we, ram_addr, ram_din);
    else pass_cnt++;
    total_cnt++;
    if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) $display("FAIL rd_gnt: got %b%b exp 01", gnt_0, gnt_1);
    else pass_cnt++;
    tick();
    req_1 = 0;
    #3;
    total_cnt++;
    if (ram_we !== 1'b0 || ram_addr !== 6'd7 || rvalid_1 !== 1'b0)
      $display("FAIL rd_cmd: got we=%b a=%h v=%b exp 0/07/0", ram_we, ram_addr, rvalid_1);
    else pass_cnt++;
    tick();
    #3;
    total_cnt++;
    if (rvalid_1 !== 1'b1 || rdata_1 !== 8'hAA || rvalid_0 !== 1'b0)
      $display("FAIL rd_ret: got v1=%b d=%h v0=%b exp 1/aa/0", rvalid_1, rdata_1, rvalid_0);
    else pass_cnt++;
    tick();
    #3;
    total_cnt++;
    if (rvalid_1 !== 1'b0 || rdata_1 !== 8'hAA)
      $display("FAIL rd_hold: got v1=%b d=%h exp 0/aa", rvalid_1, rdata_1);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] e0;
    logic [3:0] e1;
    e0 = 4'b0101;
    e1 = 4'b1010;
    do_reset();
    req_1 = 1;
    #3;
    total_cnt++;
    if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) $display("FAIL rr_single: got %b%b exp 01", gnt_0, gnt_1);
    else pass_cnt++;
    req_1 = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_0 = 1; req_1 = 1; addr_0 = 6'(i); addr_1 = 6'(i + 8);
      #3;
      total_cnt++;
      if (gnt_0 !== e0[i] || gnt_1 !== e1[i])
        $display("FAIL rr_cyc%0d: got %b%b exp %b%b", i, gnt_0, gnt_1, e0[i], e1[i]);
      else pass_cnt++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_burst_lock();
    logic [5:0] e0;
    logic [5:0] e1;
    e0 = 6'b101111;
    e1 = 6'b010000;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req_0 = 1; lock_0 = 1; req_1 = 1;
      #3;
      total_cnt++;
      if (gnt_0 !== e0[i] || gnt_1 !== e1[i])
        $display("FAIL burst_cyc%0d: got %b%b exp %b%b", i, gnt_0, gnt_1, e0[i], e1[i]);
      else pass_cnt++;
      tick();
    end
    idle_inputs();
    #3;
    total_cnt++;
    if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0) $display("FAIL burst_drop: got %b%b exp 00", gnt_0, gnt_1);
    else pass_cnt++;
    tick();
    tick();
    tick();
  endtask

  task automatic test_wr_then_rd();
    do_reset();
    req_0 = 1; we_0 = 1; addr_0 = 6'd20; wdata_0 = 8'h11;
    tick();
    we_0 = 0;
    #3;
    total_cnt++;
    if (gnt_0 !== 1'b1) $display("FAIL wtr_gnt: got %b exp 1", gnt_0);
    else pass_cnt++;
    tick();
    req_0 = 0;
    #3;
    total_cnt++;
    if (rvalid_0 !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 6'd20)
      $display("FAIL wtr_cmd: got v=%b we=%b a=%h exp 0/0/14", rvalid_0, ram_we, ram_addr);
    else pass_cnt++;
    tick();
    #3;
    total_cnt++;
    if (rvalid_0 !== 1'b1 || rdata_0 !== 8'h11)
      $display("FAIL wtr_ret: got v=%b d=%h exp 1/11", rvalid_0, rdata_0);
    else pass_cnt++;
    tick();
    #3;
    total_cnt++;
    if (rvalid_0 !== 1'b0 || rdata_0 !== 8'h11)
      $display("FAIL wtr_hold: got v=%b d=%h exp 0/11", rvalid_0, rdata_0);
    else pass_cnt++;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    req_1 = 1; we_1 = 0; addr_1 = 6'd7;
    #3;
    total_cnt++;
    if (gnt_1 !== 1'b1) $display("FAIL rif_gnt: got %b exp 1", gnt_1);
    else pass_cnt++;
    tick();
    req_1 = 0; req_0 = 1; rst = 1;
    #3;
    total_cnt++;
    if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0) $display("FAIL rif_mask: got %b%b exp 00", gnt_0, gnt_1);
    else pass_cnt++;
    tick();
    rst = 0; req_0 = 0;
    #3;
    total_cnt++;
    if (rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0 || rdata_0 !== 8'd0 || rdata_1 !== 8'd0)
      $display("FAIL rif_rd: got v=%b%b d0=%h d1=%h exp 0", rvalid_0, rvalid_1, rdata_0, rdata_1);
    else pass_cnt++;
    total_cnt++;
    if (ram_we !== 1'b0 || ram_addr !== 6'd0 || ram_din !== 8'd0)
      $display("FAIL rif_ram: got we=%b a=%h d=%h exp 0/0/0", ram_we, ram_addr, ram_din);
    else pass_cnt++;
    tick();
    #3;
    total_cnt++;
    if (rvalid_1 !== 1'b0) $display("FAIL rif_late: got %b exp 0", rvalid_1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_0 = 1; we_0 = 1; addr_0 = 6'd20; wdata_0 = 8'h3C;
    tick();
    req_0 = 0; we_0 = 0; req_1 = 1; we_1 = 1; addr_1 = 6'd30; wdata_1 = 8'hC3;
    tick();
    req_0 = 1; we_0 = 0; we_1 = 0;
    #3;
    total_cnt++;
    if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) $display("FAIL b2b_g0: got %b%b exp 10", gnt_0, gnt_1);
    else pass_cnt++;
    tick();
    req_0 = 0;
    #3;
    total_cnt++;
    if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) $display("FAIL b2b_g1: got %b%b exp 01", gnt_0, gnt_1);
    else pass_cnt++;
    tick();
    req_1 = 0;
    #3;
    total_cnt++;
    if (rvalid_0 !== 1'b1 || rdata_0 !== 8'h3C || rvalid_1 !== 1'b0)
      $display("FAIL b2b_r0: got v0=%b d0=%h v1=%b exp 1/3c/0", rvalid_0, rdata_0, rvalid_1);
    else pass_cnt++;
    tick();
    #3;
    total_cnt++;
    if (rvalid_1 !== 1'b1 || rdata_1 !== 8'hC3 || rvalid_0 !== 1'b0)
      $display("FAIL b2b_r1: got v1=%b d1=%h v0=%b exp 1/c3/0", rvalid_1, rdata_1, rvalid_0);
    else pass_cnt++;
    tick();
    #3;
    total_cnt++;
    if (rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0 || rdata_0 !== 8'h3C)
      $display("FAIL b2b_end: got v=%b%b d0=%h exp 00/3c", rvalid_0, rvalid_1, rdata_0);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_burst_lock();
    test_wr_then_rd();
    test_reset_inflight();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
